fifo_to_mem: RTL and testbench
==============================

Name: fifo_to_mem

Overview:
- Downstream consumer of the synchronous FIFO.
- Drains a programmed number of words from the FIFO read port and writes them to consecutive addresses of a single-port block RAM, starting at a base address.
- Sits between the FIFO output (rd/empty/r_data) and the memory write port.
- Controlled by a start/busy/done handshake from the system controller.

Parameters:
- DATA_WIDTH, 4: bits per FIFO word and per memory word.
- MEM_ADDR_WIDTH, 8: memory address bits; the address wraps modulo 2^MEM_ADDR_WIDTH.
- TIMEOUT_CYCLES, 16: empty-stall limit; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  MEM_ADDR_WIDTH  first memory address; latched on accepted start.
- length  in  MEM_ADDR_WIDTH+1  words to transfer, 0..2^MEM_ADDR_WIDTH; latched on accepted start.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_data  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty=0.
- fifo_rd  out  1  FIFO pop strobe (combinational).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  MEM_ADDR_WIDTH  memory write address (registered).
- mem_wdata  out  DATA_WIDTH  memory write data (registered).
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle completion pulse.
- word_cnt  out  MEM_ADDR_WIDTH+1  words written in the current or last transfer.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE. fifo_rd, mem_we, done, busy = 0. mem_addr, mem_wdata, word_cnt = 0. Reset mid-transfer aborts immediately; no further pops or writes; the FIFO is left as-is.
- States: IDLE, XFER, DONE.
- IDLE:
  - start=1 latches base_addr into cur_addr, length into remaining, and clears word_cnt.
  - Next state is XFER if length≠0, else DONE.
- XFER:
  - fifo_rd = ~fifo_empty & (remaining≠0). This is the only state that pops.
  - On a pop at edge t: mem_we=1, mem_addr=cur_addr, mem_wdata=fifo_r_data in cycle t+1. cur_addr increments (wraps FF→00 for width 8). remaining decrements, word_cnt increments.
  - When fifo_empty=1: no pop, and mem_we=0 in the following cycle. No bubbles are inserted when data is available, so throughput is 1 word/cycle.
  - The pop that makes remaining 0 moves the state to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1. This coincides with mem_we for the final word. For length 0, mem_we=0.
  - Next state is IDLE.
- start while busy, or in the DONE cycle, is ignored (not queued).
- A start in the same cycle done=1 is ignored. A new start is accepted from the following IDLE cycle.
- word_cnt holds its final value in IDLE until the next accepted start.
- mem_we is never asserted in IDLE except in the cycle directly after the final pop (the DONE cycle).

Optional Feature:
- FIFO_TO_MEM_TIMEOUT_EN defined:
  - Adds output timeout (1 bit, reset 0) and a stall counter.
  - In XFER, each cycle with fifo_empty=1 increments the counter; any pop clears it.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to DONE: done=1 and timeout=1 for that one cycle. word_cnt equals the words actually written.
- Not defined:
  - No timeout port and no counter.
  - XFER waits indefinitely for data.

Test Plan:
- Reset: drive reset=0 mid-XFER after 2 pops -> all outputs 0 asynchronously; after release, state IDLE, no fifo_rd even with fifo_empty=0.
- Basic: FIFO holds A,B,C,D; start with base=0x10, length=4 -> fifo_rd high 4 consecutive cycles; mem writes (0x10,A)(0x11,B)(0x12,C)(0x13,D) each one cycle after its pop; done=1 with the 0x13 write; word_cnt=4.
- Gaps: length=3; fifo_empty toggles 0,1,1,0,1,0 -> pops only when not empty; 3 writes in order, no mem_we in gap cycles; done with third write.
- Wrap: base=0xFE, length=4 -> addresses FE, FF, 00, 01.
- Zero length / ignored start: start with length=0 -> done one cycle later, no fifo_rd, no mem_we, word_cnt=0. start pulsed during XFER -> no effect on remaining or address.
- Timeout (FIFO_TO_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16): length=5, FIFO supplies 2 words then stays empty -> done and timeout high together on the 16th empty cycle; word_cnt=2.

Source files
------------

// File: rtl/fifo_to_mem.sv
// fifo_to_mem: drains a programmed number of FIFO words into consecutive RAM addresses.
// Define FIFO_TO_MEM_TIMEOUT_EN to add an empty-stall timeout that ends a transfer early.
module fifo_to_mem #(
    parameter int DATA_WIDTH     = 4,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [MEM_ADDR_WIDTH:0]   length,
    input  logic                      fifo_empty,
    input  logic [DATA_WIDTH-1:0]     fifo_r_data,
    output logic                      fifo_rd,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic                      busy,
    output logic                      done,
`ifdef FIFO_TO_MEM_TIMEOUT_EN
    output logic                      timeout,
`endif
    output logic [MEM_ADDR_WIDTH:0]   word_cnt
);
    localparam int AW = MEM_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cur_addr;
    logic [AW:0]   remaining;
    logic          pop;
    logic          last_pop;

`ifdef FIFO_TO_MEM_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall_cnt;
    logic          stall_hit;
    assign stall_hit = (state == XFER) && fifo_empty && (stall_cnt == SW'(TIMEOUT_CYCLES - 1));
`endif

    assign pop      = (state == XFER) && !fifo_empty && (remaining != '0);
    assign last_pop = pop && (remaining == (AW+1)'(1));
    assign fifo_rd  = pop;
    assign busy     = state != IDLE;
    assign done     = state == DONE;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = !start ? IDLE : (length != '0) ? XFER : DONE;
`ifdef FIFO_TO_MEM_TIMEOUT_EN
            XFER:    state_nxt = (last_pop || stall_hit) ? DONE : XFER;
`else
            XFER:    state_nxt = last_pop ? DONE : XFER;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            word_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= pop;
            if (state == IDLE && start) begin
                cur_addr  <= base_addr;
                remaining <= length;
                word_cnt  <= '0;
            end
            if (pop) begin
                mem_addr  <= cur_addr;
                mem_wdata <= fifo_r_data;
                cur_addr  <= cur_addr + AW'(1);
                remaining <= remaining - (AW+1)'(1);
                word_cnt  <= word_cnt + (AW+1)'(1);
            end
        end
    end

`ifdef FIFO_TO_MEM_TIMEOUT_EN
    // The stall count only survives consecutive empty cycles inside XFER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            stall_cnt <= (state == XFER && fifo_empty && !stall_hit) ? stall_cnt + SW'(1) : '0;
            timeout   <= stall_hit;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_to_mem.sv
// tb_fifo_to_mem: randomized scoreboard bench; a queue-based FIFO model feeds the DUT and
// the expected write stream is derived from the FIFO contents, base address and length.
module tb_fifo_to_mem;
    localparam int DW = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_r_data = '0;
    logic          fifo_rd, mem_we, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   word_cnt;
`ifdef FIFO_TO_MEM_TIMEOUT_EN
    logic          timeout;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] fifo_q[$];
    wr_t           exp_q[$];
    wr_t           e;
    int            exp_cnt = 0;
    logic          exp_we_done = 1'b0;
    logic          exp_to = 1'b0;
    int            done_cnt = 0;
    int            pop_cnt = 0;
    int            gap_mode = 0;
    int            gap_idx = 0;
    logic          prev_rd = 1'b0;
    logic          gap = 1'b0;
    logic [5:0]    pat = 6'b010110;

    always #5 clk = ~clk;

    fifo_to_mem #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data), .fifo_rd(fifo_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
`ifdef FIFO_TO_MEM_TIMEOUT_EN
        .timeout(timeout),
`endif
        .word_cnt(word_cnt)
    );

    // FIFO model: pops on the edge, presents the next head shortly after it.
    always @(posedge clk) begin
        if (fifo_rd && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
        end
        #1;
        gap = (gap_mode == 1) ? ($urandom_range(0, 2) == 0) : (gap_mode == 2) ? pat[gap_idx % 6] : 1'b0;
        gap_idx++;
        fifo_empty = gap || fifo_q.size() == 0;
        fifo_r_data = fifo_q.size() > 0 ? fifo_q[0] : '0;
    end

    always @(negedge clk) begin
        if (!reset) prev_rd = 1'b0;
        else begin
            total++;
            if (mem_we !== prev_rd) begin
                bad++;
                $display("FAIL we_latency: mem_we=%b, pop on previous edge=%b", mem_we, prev_rd);
            end
            if (fifo_rd) begin
                total++;
                if (fifo_empty || !busy) begin
                    bad++;
                    $display("FAIL rd_cond: fifo_rd=1 with fifo_empty=%b busy=%b", fifo_empty, busy);
                end
            end
            if (mem_we) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_extra: write addr=%h data=%h, none expected", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.a || mem_wdata !== e.d) begin
                        bad++;
                        $display("FAIL wr: got addr=%h data=%h want addr=%h data=%h", mem_addr, mem_wdata, e.a, e.d);
                    end
                end
            end
            if (done) begin
                total++;
                done_cnt++;
                if (exp_q.size() != 0 || word_cnt != exp_cnt || mem_we !== exp_we_done || !busy
`ifdef FIFO_TO_MEM_TIMEOUT_EN
                    || timeout !== exp_to
`endif
                ) begin
                    bad++;
                    $display("FAIL done: pending=%0d word_cnt=%0d mem_we=%b busy=%b, want pending=0 word_cnt=%0d mem_we=%b busy=1 (timeout want %b)",
                             exp_q.size(), word_cnt, mem_we, busy, exp_cnt, exp_we_done, exp_to);
                end
            end
            prev_rd = fifo_rd;
        end
    end

    task automatic fill(input int n);
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input int len, input int words, input int gm,
                            input bit poke, input bit hold);
        int d0, n, to;
        logic [AW:0] wc;
        gap_mode = gm;
        gap_idx = 0;
        fill(words);
        @(posedge clk); #2;
        n = (len < words) ? len : words;
        for (int i = 0; i < n; i++) exp_q.push_back(wr_t'{a: AW'(int'(b) + i), d: fifo_q[i]});
        exp_cnt = n;
        exp_we_done = (n != 0) && (len <= words);
        exp_to = words < len;
        d0 = done_cnt;
        base_addr = b;
        length = (AW+1)'(len);
        start = 1'b1;
        @(posedge clk); #2;
        if (hold) begin @(posedge clk); #2; end
        start = 1'b0;
        if (poke) begin
            @(posedge clk); #2;
            start = 1'b1; base_addr = ~b; length = 3;
            @(posedge clk); #2;
            start = 1'b0;
        end
        to = 0;
        while (done_cnt == d0 && to < len * 8 + 600) begin
            @(posedge clk); #2;
            to++;
        end
        total++;
        if (done_cnt != d0 + 1 || busy || mem_we || done || word_cnt != exp_cnt || fifo_q.size() != words - n) begin
            bad++;
            $display("FAIL xfer_end: done pulses=%0d busy=%b mem_we=%b done=%b word_cnt=%0d fifo left=%0d, want 1 0 0 0 %0d %0d",
                     done_cnt - d0, busy, mem_we, done, word_cnt, fifo_q.size(), exp_cnt, words - n);
        end
        wc = word_cnt;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (word_cnt != exp_cnt || busy || exp_q.size() != 0) begin
            bad++;
            $display("FAIL idle_hold: word_cnt=%0d busy=%b pending=%0d, want %0d 0 0", word_cnt, busy, exp_q.size(), wc);
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        if (fifo_rd || mem_we || done || busy || mem_addr != 0 || mem_wdata != 0 || word_cnt != 0) begin
            bad++;
            $display("FAIL %s: rd=%b we=%b done=%b busy=%b addr=%h data=%h cnt=%0d, want all zero",
                     tag, fifo_rd, mem_we, done, busy, mem_addr, mem_wdata, word_cnt);
        end
    endtask

    initial begin
        int p0, len;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        reset = 1'b1;
        run_xfer(8'h10, 4, 6, 0, 0, 0);
        run_xfer(8'h20, 3, 3, 2, 0, 0);
        run_xfer(8'hFE, 4, 5, 0, 0, 0);
        run_xfer(8'h30, 0, 3, 0, 0, 1);
        run_xfer(8'h50, 6, 7, 0, 1, 0);
        run_xfer(8'h80, 256, 258, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            len = $urandom_range(1, 20);
            run_xfer(AW'($urandom), len, len + $urandom_range(0, 3), $urandom_range(0, 1), 0, 0);
        end
        gap_mode = 0;
        fill(6);
        @(posedge clk); #2;
        p0 = pop_cnt;
        base_addr = 8'h40; length = 6; start = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(wr_t'{a: AW'(8'h40 + i), d: fifo_q[i]});
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 20 && pop_cnt < p0 + 2; i++) begin
            @(posedge clk); #3;
        end
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_zero("reset_async");
        @(posedge clk); #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (fifo_rd || busy || fifo_empty || fifo_q.size() != 4) begin
                bad++;
                $display("FAIL post_reset: rd=%b busy=%b empty=%b fifo left=%0d, want 0 0 0 4", fifo_rd, busy, fifo_empty, fifo_q.size());
            end
        end
`ifdef FIFO_TO_MEM_TIMEOUT_EN
        run_xfer(8'h60, 5, 2, 0, 0, 0);
`endif
        run_xfer(8'h70, 5, 5, 1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
